// File: rtl/mips_pkg.sv
// Shared MIPS datapath types: multiply/divide opcodes, unit FSM states and a
// width-generic two's-complement negate helper.
package mips_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } muldiv_state_t;

  // Callers zero-extend into NEG_W bits and truncate the result back down.
  localparam int unsigned NEG_W = 128;

  function automatic logic [NEG_W-1:0] neg(input logic [NEG_W-1:0] x);
    return (~x) + NEG_W'(1);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; one result bit per
// cycle on operand magnitudes, sign correction applied in a final FIX cycle.
module mul_div_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W2       = 2 * WIDTH;
  localparam int unsigned CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  muldiv_state_t    state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             b_zero_q, b_zero_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] addend_q, addend_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             signed_op, div_op;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_part, div_diff;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quot, rem;

  always_comb begin
    signed_op = (op == MD_MULT) || (op == MD_DIV);
    div_op    = (op == MD_DIV) || (op == MD_DIVU);
    mag_a     = (signed_op && a[WIDTH-1]) ? WIDTH'(neg(NEG_W'(a))) : a;
    mag_b     = (signed_op && b[WIDTH-1]) ? WIDTH'(neg(NEG_W'(b))) : b;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, addend_q};
    div_part  = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_part - {1'b0, addend_q};

    prod = neg_res_q ? W2'(neg(NEG_W'(acc_q))) : acc_q;
    quot = neg_res_q ? WIDTH'(neg(NEG_W'(acc_q[WIDTH-1:0]))) : acc_q[WIDTH-1:0];
    rem  = neg_rem_q ? WIDTH'(neg(NEG_W'(acc_q[W2-1:WIDTH]))) : acc_q[W2-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    b_zero_d  = b_zero_q;
    a_d       = a_q;
    addend_d  = addend_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d  = div_op;
          neg_res_d = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = signed_op && a[WIDTH-1];
          b_zero_d  = (b == '0);
          a_d       = a;
          addend_d  = div_op ? mag_b : mag_a;
          acc_d     = {{WIDTH{1'b0}}, (div_op ? mag_a : mag_b)};
          cnt_d     = '0;
          state_d   = RUN;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end

      RUN: begin
        if (is_div_q) begin
          if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                  acc_d = {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else if (acc_q[0]) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
          acc_d = {1'b0, acc_q[W2-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = FIX;
      end

      FIX: begin
        // MIN / -1 needs no special case: magnitude quotient is already MIN.
        if (!is_div_q) begin
          hi_d = prod[W2-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (b_zero_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      a_q       <= '0;
      addend_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      b_zero_q  <= b_zero_d;
      a_q       <= a_d;
      addend_q  <= addend_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vectors, handshake corner
// sequences and randomized operations against an arithmetic reference model.
module tb_mul_div_unit;
  import mips_pkg::*;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           reset, start, hi_we, lo_we;
  muldiv_op_t     op;
  logic [W-1:0]   a, b, wdata, hi, lo;
  logic           busy, done;

  int unsigned    cyc = 0;
  int unsigned    t0 = 0;
  int unsigned    n_chk = 0;
  int unsigned    n_pass = 0;
  logic [W-1:0]   m_hi = '0;
  logic [W-1:0]   m_lo = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    muldiv_op_t   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic void ref_model(input muldiv_op_t o, input logic [W-1:0] x, input logic [W-1:0] y,
                                    output logic [W-1:0] rh, output logic [W-1:0] rl);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    logic [63:0]     p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    rh = '0;
    rl = '0;
    case (o)
      MD_MULT:  begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
      MD_MULTU: begin p = ux * uy;      rh = p[63:32]; rl = p[31:0]; end
      MD_DIV: begin
        if (y == '0) begin rh = x; rl = '1; end
        else begin
          sq = sx / sy; sr = sx % sy;
          p = 64'(sq); rl = p[31:0];
          p = 64'(sr); rh = p[31:0];
        end
      end
      default: begin
        if (y == '0) begin rh = x; rl = '1; end
        else begin
          uq = ux / uy; ur = ux % uy;
          rl = uq[31:0];
          rh = ur[31:0];
        end
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; leaves at the negedge of cycle 1 with operands scrambled.
  task automatic issue(input muldiv_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    op = muldiv_op_t'(2'($urandom_range(0, 3)));
    a = $urandom;
    b = $urandom;
  endtask

  // Waits for done, checking busy and HI/LO stability each cycle; returns at the done-cycle negedge.
  task automatic run_check(input string nm, input logic [W-1:0] eh, input logic [W-1:0] el);
    int unsigned lat = 0;
    int unsigned berr = 0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        lat = cyc - t0;
        if (busy) berr++;
        break;
      end
      if (!busy || hi !== m_hi || lo !== m_lo) berr++;
      @(negedge clk);
    end
    chk({nm, "_latency"}, 64'(lat), 64'(W + 2));
    chk({nm, "_busy_hold"}, 64'(berr), 64'd0);
    chk({nm, "_hi"}, 64'(hi), 64'(eh));
    chk({nm, "_lo"}, 64'(lo), 64'(el));
    m_hi = eh;
    m_lo = el;
  endtask

  vec_t         tbl[12];
  muldiv_op_t   ro;
  logic [W-1:0] rx, ry, rh, rl;
  int unsigned  dcount;

  initial begin
    tbl[0]  = '{MD_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[1]  = '{MD_MULTU, 32'hFFFF_FFFF,  32'd2,         32'h0000_0001, 32'hFFFF_FFFE};
    tbl[2]  = '{MD_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3]  = '{MD_DIVU,  32'd7,          32'd0,         32'h0000_0007, 32'hFFFF_FFFF};
    tbl[4]  = '{MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[5]  = '{MD_DIV,   32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    tbl[6]  = '{MD_DIVU,  32'd100,        32'd7,         32'd2,         32'd14};
    tbl[7]  = '{MD_DIV,   32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    tbl[8]  = '{MD_MULT,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    tbl[9]  = '{MD_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[10] = '{MD_DIVU,  32'hFFFF_FFFF,  32'd1,         32'h0000_0000, 32'hFFFF_FFFF};
    tbl[11] = '{MD_MULT,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = MD_MULT; a = '0; b = '0; wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      run_check($sformatf("vec%0d", i), tbl[i].hi, tbl[i].lo);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
    end

    // Overflow divide, then a start in its done cycle, then ignored start/MTHI while busy.
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("ovf", 32'h0, 32'h8000_0000);
    issue(MD_MULTU, 32'd3, 32'd5);
    chk("b2b_busy", 64'(busy), 64'd1);
    repeat (4) @(negedge clk);
    start = 1'b1; op = MD_DIVU; a = 32'd100; b = 32'd7;
    hi_we = 1'b1; wdata = 32'hAAAA_5555;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    run_check("ign", 32'd0, 32'd15);

    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'h1234_5678);
    chk("mtlo_hi", 64'(hi), 64'd0);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mtboth_hi", 64'(hi), 64'hCAFE_F00D);
    chk("mtboth_lo", 64'(lo), 64'hCAFE_F00D);
    m_hi = 32'hCAFE_F00D; m_lo = 32'hCAFE_F00D;

    hi_we = 1'b1; wdata = 32'h5;
    issue(MD_MULTU, 32'd2, 32'd2);
    hi_we = 1'b0;
    chk("start_wins_hi", 64'(hi), 64'hCAFE_F00D);
    run_check("start_wins", 32'd0, 32'd4);

    // Reset in cycle 10 of a divide.
    issue(MD_DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    m_hi = '0; m_lo = '0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("abort_quiet", 64'(dcount), 64'd0);
    issue(MD_MULT, 32'd2, 32'd3);
    run_check("after_abort", 32'd0, 32'd6);

    for (int i = 0; i < 40; i++) begin
      ro = muldiv_op_t'(2'($urandom_range(0, 3)));
      rx = pick();
      ry = pick();
      ref_model(ro, rx, ry, rh, rl);
      issue(ro, rx, ry);
      run_check($sformatf("rnd%0d_op%0d_%0h_%0h", i, ro, rx, ry), rh, rl);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
